// File: rtl/tdt_dm_abscmd_ctrl_if.sv
// tdt_dm_abscmd_ctrl_if: DM-register-file and DTU signals of the abstract-command sequencer.
// Optional TDT_DM_ABSCMD_AUTOEXEC_EN adds autoexec_data0/data0_acc.
interface tdt_dm_abscmd_ctrl_if #(
    parameter int XLEN = 32
);
    logic            cmd_vld;
    logic [31:0]     cmd_word;
    logic [XLEN-1:0] data0_in;
    logic [2:0]      cmderr_clr;
    logic            data0_upd_vld;
    logic [XLEN-1:0] data0_upd_data;
    logic            busy;
    logic [2:0]      cmderr;
    logic            dtu_tdt_dm_halted;
    logic [31:0]     tdt_dm_dtu_itr;
    logic            tdt_dm_dtu_itr_vld;
    logic            dtu_tdt_dm_itr_done;
    logic            dtu_tdt_dm_retire_debug_expt_vld;
    logic            tdt_dm_dtu_wr_vld;
    logic [1:0]      tdt_dm_dtu_wr_flg;
    logic [XLEN-1:0] tdt_dm_dtu_wdata;
    logic            dtu_tdt_dm_wr_ready;
    logic [XLEN-1:0] dtu_tdt_dm_rx_data;
`ifdef TDT_DM_ABSCMD_AUTOEXEC_EN
    logic            autoexec_data0;
    logic            data0_acc;
`endif

    // Sequencer side
    modport master (
        input  cmd_vld, cmd_word, data0_in, cmderr_clr, dtu_tdt_dm_halted,
               dtu_tdt_dm_itr_done, dtu_tdt_dm_retire_debug_expt_vld,
               dtu_tdt_dm_wr_ready, dtu_tdt_dm_rx_data,
`ifdef TDT_DM_ABSCMD_AUTOEXEC_EN
        input  autoexec_data0, data0_acc,
`endif
        output data0_upd_vld, data0_upd_data, busy, cmderr, tdt_dm_dtu_itr,
               tdt_dm_dtu_itr_vld, tdt_dm_dtu_wr_vld, tdt_dm_dtu_wr_flg, tdt_dm_dtu_wdata
    );

    // Register file / DTU side
    modport slave (
        output cmd_vld, cmd_word, data0_in, cmderr_clr, dtu_tdt_dm_halted,
               dtu_tdt_dm_itr_done, dtu_tdt_dm_retire_debug_expt_vld,
               dtu_tdt_dm_wr_ready, dtu_tdt_dm_rx_data,
`ifdef TDT_DM_ABSCMD_AUTOEXEC_EN
        output autoexec_data0, data0_acc,
`endif
        input  data0_upd_vld, data0_upd_data, busy, cmderr, tdt_dm_dtu_itr,
               tdt_dm_dtu_itr_vld, tdt_dm_dtu_wr_vld, tdt_dm_dtu_wr_flg, tdt_dm_dtu_wdata
    );
endinterface

// File: rtl/tdt_dm_abscmd_ctrl.sv
// tdt_dm_abscmd_ctrl: Access Register abstract command to DTU scratch/instruction sequence.
// Optional TDT_DM_ABSCMD_AUTOEXEC_EN relaunches the last command on a data0 access.
module tdt_dm_abscmd_ctrl #(
    parameter int XLEN    = 32,
    parameter int ITR_TMO = 255
) (
    input logic                   sys_apb_clk,
    input logic                   sys_apb_rst,
    tdt_dm_abscmd_ctrl_if.master  abscmd_if
);
    typedef enum logic [2:0] {IDLE, CHK, WSCR, ITR, RSCR, DONE} state_e;

    state_e          state_q, state_d;
    logic [31:0]     cmd_q, cmd_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [2:0]      cmderr_q, cmderr_d;
    logic [7:0]      tmo_q, tmo_d;
    logic            upd_vld_q, upd_vld_d;
    logic [XLEN-1:0] upd_data_q, upd_data_d;
    logic            launch, collide, err_vld, tmo_hit, bad_cmd;
    logic [2:0]      err_code;
    logic            unused_cmd_bits;

`ifdef TDT_DM_ABSCMD_AUTOEXEC_EN
    assign launch  = abscmd_if.cmd_vld | (abscmd_if.data0_acc & abscmd_if.autoexec_data0);
    assign collide = abscmd_if.cmd_vld | abscmd_if.data0_acc;
`else
    assign launch  = abscmd_if.cmd_vld;
    assign collide = abscmd_if.cmd_vld;
`endif

    assign unused_cmd_bits = ^{cmd_q[23], cmd_q[19:18]};
    assign tmo_hit = tmo_q == 8'(ITR_TMO);
    // Only Access Register, 32-bit, GPR x0..x31 (regno 0x1000-0x101F) is supported
    assign bad_cmd = (cmd_q[31:24] != 8'd0) |
                     (cmd_q[17] & ((cmd_q[22:20] != 3'd2) | (cmd_q[15:5] != 11'h080)));

    // Next-state, timeout counter, data0 update and cmderr resolution
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        tmo_d      = tmo_q + 8'd1;
        upd_vld_d  = 1'b0;
        upd_data_d = upd_data_q;
        err_vld    = 1'b0;
        err_code   = 3'd0;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = CHK;
                    data_d  = abscmd_if.data0_in;
                    if (abscmd_if.cmd_vld) cmd_d = abscmd_if.cmd_word;
                end
            end
            CHK: begin
                tmo_d = 8'd0;
                if (cmderr_q != 3'd0) begin
                    state_d = DONE;
                end else if (!abscmd_if.dtu_tdt_dm_halted) begin
                    err_vld  = 1'b1;
                    err_code = 3'd4;
                    state_d  = DONE;
                end else if (bad_cmd) begin
                    err_vld  = 1'b1;
                    err_code = 3'd2;
                    state_d  = DONE;
                end else begin
                    state_d = !cmd_q[17] ? DONE : cmd_q[16] ? WSCR : ITR;
                end
            end
            WSCR: begin
                if (abscmd_if.dtu_tdt_dm_wr_ready) begin
                    state_d = ITR;
                    tmo_d   = 8'd0;
                end else if (tmo_hit) begin
                    err_vld  = 1'b1;
                    err_code = 3'd7;
                    state_d  = DONE;
                end
            end
            ITR: begin
                if (abscmd_if.dtu_tdt_dm_retire_debug_expt_vld) begin
                    err_vld  = 1'b1;
                    err_code = 3'd3;
                    state_d  = DONE;
                end else if (abscmd_if.dtu_tdt_dm_itr_done) begin
                    state_d = cmd_q[16] ? DONE : RSCR;
                    tmo_d   = 8'd0;
                end else if (tmo_hit) begin
                    err_vld  = 1'b1;
                    err_code = 3'd7;
                    state_d  = DONE;
                end
            end
            RSCR: begin
                if (abscmd_if.dtu_tdt_dm_wr_ready) begin
                    upd_vld_d  = 1'b1;
                    upd_data_d = abscmd_if.dtu_tdt_dm_rx_data;
                    state_d    = DONE;
                end else if (tmo_hit) begin
                    err_vld  = 1'b1;
                    err_code = 3'd7;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && collide && !err_vld) begin
            err_vld  = 1'b1;
            err_code = 3'd1;
        end
        cmderr_d = cmderr_q & ~abscmd_if.cmderr_clr;
        if (err_vld && cmderr_d == 3'd0) cmderr_d = err_code;
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge sys_apb_clk) begin
        if (sys_apb_rst) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            data_q     <= '0;
            cmderr_q   <= '0;
            tmo_q      <= '0;
            upd_vld_q  <= 1'b0;
            upd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            cmderr_q   <= cmderr_d;
            tmo_q      <= tmo_d;
            upd_vld_q  <= upd_vld_d;
            upd_data_q <= upd_data_d;
        end
    end

    // Outputs decode from state so valids drop the cycle a sequence leaves its state
    assign abscmd_if.busy               = state_q != IDLE;
    assign abscmd_if.cmderr             = cmderr_q;
    assign abscmd_if.data0_upd_vld      = upd_vld_q;
    assign abscmd_if.data0_upd_data     = upd_data_q;
    assign abscmd_if.tdt_dm_dtu_wr_vld  = (state_q == WSCR) | (state_q == RSCR);
    assign abscmd_if.tdt_dm_dtu_wr_flg  = state_q == WSCR ? 2'b01 : state_q == RSCR ? 2'b10 : 2'b00;
    assign abscmd_if.tdt_dm_dtu_wdata   = state_q == WSCR ? data_q : '0;
    assign abscmd_if.tdt_dm_dtu_itr_vld = state_q == ITR;
    // Write moves dscratch (0x7b2) into xr; read moves xr into dscratch
    assign abscmd_if.tdt_dm_dtu_itr     = state_q != ITR ? 32'd0 :
                                          cmd_q[16] ? {12'h7b2, 5'd0, 3'b010, cmd_q[4:0], 7'h73} :
                                                      {12'h7b2, cmd_q[4:0], 3'b001, 5'd0, 7'h73};
endmodule

// File: tb/tb_tdt_dm_abscmd_ctrl.sv
// tb_tdt_dm_abscmd_ctrl: scoreboard bench for the abstract-command sequencer.
module tb_tdt_dm_abscmd_ctrl;
    localparam int XLEN = 32;
    localparam logic [2:0] K_WR = 3'd1, K_RD = 3'd2, K_ITR = 3'd3, K_UPD = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdt_dm_abscmd_ctrl_if #(.XLEN(XLEN)) bus ();
    tdt_dm_abscmd_ctrl #(.XLEN(XLEN), .ITR_TMO(255)) dut (
        .sys_apb_clk(clk),
        .sys_apb_rst(rst),
        .abscmd_if  (bus)
    );

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          wr_dly, itr_dly, upd_seen, vld_max;
    bit          no_ready, expt_en;
    logic [31:0] rx_val;

    task automatic push(input logic [2:0] k, input logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic drive_cmd(input logic [31:0] word, input logic [31:0] d0);
        bus.cmd_word = word;
        bus.data0_in = d0;
        bus.cmd_vld  = 1'b1;
        @(negedge clk);
        bus.cmd_vld  = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_cmd: got %b exp 1", bus.busy);
        end
    endtask

    task automatic clear_err();
        bus.cmderr_clr = 3'b111;
        @(negedge clk);
        bus.cmderr_clr = 3'b000;
    endtask

    // Per-cycle DTU responder plus scoreboard monitor until busy falls
    task automatic service(input int budget, input int coll_at, input logic [31:0] coll_word);
        int wcnt = 0, icnt = 0, cyc = 0, run = 0;
        logic pw = 1'b0, pi = 1'b0, pu = 1'b0;
        logic [1:0] pflg = 2'b00;
        logic [31:0] pwd = '0;
        exp_t e;
        upd_seen = 0;
        vld_max  = 0;
        forever begin
            bus.cmd_vld = (cyc == coll_at);
            if (cyc == coll_at) bus.cmd_word = coll_word;
            if (bus.tdt_dm_dtu_wr_vld || bus.tdt_dm_dtu_itr_vld) begin
                checks++;
                if (bus.tdt_dm_dtu_wr_vld && bus.tdt_dm_dtu_itr_vld) begin
                    errors++;
                    $display("FAIL both_valid: got wr_vld=1 itr_vld=1 exp not both");
                end
            end
            if (bus.tdt_dm_dtu_wr_vld && !pw) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wr: got flg=%b wdata=%h exp no access", bus.tdt_dm_dtu_wr_flg, bus.tdt_dm_dtu_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind == K_WR && (bus.tdt_dm_dtu_wr_flg !== 2'b01 || bus.tdt_dm_dtu_wdata !== e.val)) begin
                        errors++;
                        $display("FAIL scratch_write: got flg=%b wdata=%h exp flg=01 wdata=%h", bus.tdt_dm_dtu_wr_flg, bus.tdt_dm_dtu_wdata, e.val);
                    end else if (e.kind == K_RD && bus.tdt_dm_dtu_wr_flg !== 2'b10) begin
                        errors++;
                        $display("FAIL scratch_read: got flg=%b exp flg=10", bus.tdt_dm_dtu_wr_flg);
                    end else if (e.kind != K_WR && e.kind != K_RD) begin
                        errors++;
                        $display("FAIL order_wr: got scratch access flg=%b exp event kind %0d", bus.tdt_dm_dtu_wr_flg, e.kind);
                    end
                end
            end
            if (bus.tdt_dm_dtu_wr_vld && pw) begin
                checks++;
                if (bus.tdt_dm_dtu_wr_flg !== pflg || bus.tdt_dm_dtu_wdata !== pwd) begin
                    errors++;
                    $display("FAIL wr_stable: got flg=%b wdata=%h exp flg=%b wdata=%h", bus.tdt_dm_dtu_wr_flg, bus.tdt_dm_dtu_wdata, pflg, pwd);
                end
            end
            if (bus.tdt_dm_dtu_itr_vld && !pi) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_itr: got itr=%h exp no instruction", bus.tdt_dm_dtu_itr);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != K_ITR || bus.tdt_dm_dtu_itr !== e.val) begin
                        errors++;
                        $display("FAIL itr: got itr=%h exp kind %0d val %h", bus.tdt_dm_dtu_itr, e.kind, e.val);
                    end
                end
            end
            if (bus.data0_upd_vld) begin
                upd_seen++;
                checks++;
                if (pu) begin
                    errors++;
                    $display("FAIL upd_pulse: got data0_upd_vld high 2 cycles exp 1");
                end
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_upd: got data=%h exp no update", bus.data0_upd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != K_UPD || bus.data0_upd_data !== e.val) begin
                        errors++;
                        $display("FAIL data0_upd: got %h exp kind %0d val %h", bus.data0_upd_data, e.kind, e.val);
                    end
                end
            end
            run = bus.tdt_dm_dtu_wr_vld ? run + 1 : 0;
            if (run > vld_max) vld_max = run;
            pw   = bus.tdt_dm_dtu_wr_vld;
            pi   = bus.tdt_dm_dtu_itr_vld;
            pu   = bus.data0_upd_vld;
            pflg = bus.tdt_dm_dtu_wr_flg;
            pwd  = bus.tdt_dm_dtu_wdata;
            if (bus.tdt_dm_dtu_wr_vld) begin
                bus.dtu_tdt_dm_wr_ready = (wcnt == wr_dly) && !no_ready;
                bus.dtu_tdt_dm_rx_data  = rx_val;
                wcnt++;
            end else begin
                bus.dtu_tdt_dm_wr_ready = 1'b0;
                wcnt = 0;
            end
            if (bus.tdt_dm_dtu_itr_vld) begin
                bus.dtu_tdt_dm_itr_done = (icnt == itr_dly);
                bus.dtu_tdt_dm_retire_debug_expt_vld = (icnt == itr_dly) && expt_en;
                icnt++;
            end else begin
                bus.dtu_tdt_dm_itr_done = 1'b0;
                bus.dtu_tdt_dm_retire_debug_expt_vld = 1'b0;
                icnt = 0;
            end
            if (!bus.busy) break;
            if (cyc == budget) begin
                errors++;
                $display("FAIL busy_timeout: got busy=1 after %0d cycles exp 0", budget);
                break;
            end
            cyc++;
            @(negedge clk);
        end
        bus.cmd_vld = 1'b0;
        bus.dtu_tdt_dm_wr_ready = 1'b0;
        bus.dtu_tdt_dm_itr_done = 1'b0;
        bus.dtu_tdt_dm_retire_debug_expt_vld = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending events exp 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.cmderr, bus.tdt_dm_dtu_itr_vld, bus.tdt_dm_dtu_wr_vld, bus.tdt_dm_dtu_wr_flg} !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b cmderr=%0d itr_vld=%b wr_vld=%b flg=%b exp all 0",
                     bus.busy, bus.cmderr, bus.tdt_dm_dtu_itr_vld, bus.tdt_dm_dtu_wr_vld, bus.tdt_dm_dtu_wr_flg);
        end
        checks++;
        if (bus.tdt_dm_dtu_itr !== 32'd0 || bus.tdt_dm_dtu_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: got itr=%h wdata=%h exp 0", bus.tdt_dm_dtu_itr, bus.tdt_dm_dtu_wdata);
        end
        checks++;
        if (bus.data0_upd_vld !== 1'b0 || bus.data0_upd_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_upd: got vld=%b data=%h exp 0", bus.data0_upd_vld, bus.data0_upd_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b exp 0", bus.busy);
        end
    endtask

    task automatic test_write();
        wr_dly = 2;
        itr_dly = 3;
        push(K_WR, 32'hDEADBEEF);
        push(K_ITR, 32'h7B20_22F3);
        drive_cmd(32'h0023_1005, 32'hDEADBEEF);
        service(50, -1, 32'd0);
        checks++;
        if (bus.busy !== 1'b0 || bus.cmderr !== 3'd0 || upd_seen != 0) begin
            errors++;
            $display("FAIL write_end: got busy=%b cmderr=%0d upd=%0d exp 0 0 0", bus.busy, bus.cmderr, upd_seen);
        end
    endtask

    task automatic test_read();
        wr_dly = 1;
        itr_dly = 0;
        rx_val = 32'h1234_5678;
        push(K_ITR, 32'h7B25_1073);
        push(K_RD, 32'd0);
        push(K_UPD, 32'h1234_5678);
        drive_cmd(32'h0022_100A, 32'h0);
        service(50, -1, 32'd0);
        checks++;
        if (bus.cmderr !== 3'd0 || upd_seen != 1 || bus.data0_upd_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL read_end: got cmderr=%0d upd=%0d data=%h exp 0 1 12345678", bus.cmderr, upd_seen, bus.data0_upd_data);
        end
    endtask

    task automatic test_expt();
        itr_dly = 1;
        expt_en = 1'b1;
        rx_val = 32'hFFFF_0000;
        push(K_ITR, 32'h7B25_1073);
        drive_cmd(32'h0022_100A, 32'h0);
        service(50, -1, 32'd0);
        expt_en = 1'b0;
        checks++;
        if (bus.cmderr !== 3'd3 || upd_seen != 0) begin
            errors++;
            $display("FAIL expt: got cmderr=%0d upd=%0d exp 3 0", bus.cmderr, upd_seen);
        end
        clear_err();
        checks++;
        if (bus.cmderr !== 3'd0) begin
            errors++;
            $display("FAIL clr: got cmderr=%0d exp 0", bus.cmderr);
        end
    endtask

    task automatic test_errors();
        bus.dtu_tdt_dm_halted = 1'b0;
        drive_cmd(32'h0023_1005, 32'h1);
        service(20, -1, 32'd0);
        bus.dtu_tdt_dm_halted = 1'b1;
        checks++;
        if (bus.cmderr !== 3'd4) begin
            errors++;
            $display("FAIL not_halted: got cmderr=%0d exp 4", bus.cmderr);
        end
        clear_err();
        drive_cmd(32'h0033_1005, 32'h1);
        service(20, -1, 32'd0);
        checks++;
        if (bus.cmderr !== 3'd2) begin
            errors++;
            $display("FAIL aarsize: got cmderr=%0d exp 2", bus.cmderr);
        end
        drive_cmd(32'h0023_1005, 32'h1);
        service(20, -1, 32'd0);
        checks++;
        if (bus.cmderr !== 3'd2) begin
            errors++;
            $display("FAIL sticky: got cmderr=%0d exp 2", bus.cmderr);
        end
        clear_err();
        drive_cmd(32'h0023_1020, 32'h1);
        service(20, -1, 32'd0);
        checks++;
        if (bus.cmderr !== 3'd2) begin
            errors++;
            $display("FAIL regno_range: got cmderr=%0d exp 2", bus.cmderr);
        end
        clear_err();
        drive_cmd(32'h0123_1005, 32'h1);
        service(20, -1, 32'd0);
        checks++;
        if (bus.cmderr !== 3'd2) begin
            errors++;
            $display("FAIL cmdtype: got cmderr=%0d exp 2", bus.cmderr);
        end
        clear_err();
        drive_cmd(32'h0020_1005, 32'h1);
        service(20, -1, 32'd0);
        checks++;
        if (bus.cmderr !== 3'd0) begin
            errors++;
            $display("FAIL noop: got cmderr=%0d exp 0", bus.cmderr);
        end
    endtask

    task automatic test_collision();
        wr_dly = 5;
        itr_dly = 1;
        push(K_WR, 32'h1122_3344);
        push(K_ITR, 32'h7B20_22F3);
        drive_cmd(32'h0023_1005, 32'h1122_3344);
        service(50, 2, 32'h0022_100A);
        checks++;
        if (bus.cmderr !== 3'd1) begin
            errors++;
            $display("FAIL collision: got cmderr=%0d exp 1", bus.cmderr);
        end
        clear_err();
    endtask

    task automatic test_timeout();
        no_ready = 1'b1;
        push(K_WR, 32'hA5A5_0001);
        drive_cmd(32'h0023_1005, 32'hA5A5_0001);
        service(400, -1, 32'd0);
        no_ready = 1'b0;
        checks++;
        if (bus.cmderr !== 3'd7 || bus.tdt_dm_dtu_wr_vld !== 1'b0) begin
            errors++;
            $display("FAIL timeout: got cmderr=%0d wr_vld=%b exp 7 0", bus.cmderr, bus.tdt_dm_dtu_wr_vld);
        end
        checks++;
        if (vld_max < 255 || vld_max > 256) begin
            errors++;
            $display("FAIL timeout_len: got %0d wr_vld cycles exp 255..256", vld_max);
        end
        clear_err();
    endtask

    task automatic test_rst_itr();
        drive_cmd(32'h0022_100A, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.tdt_dm_dtu_itr_vld !== 1'b1) begin
            errors++;
            $display("FAIL itr_enter: got itr_vld=%b exp 1", bus.tdt_dm_dtu_itr_vld);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.tdt_dm_dtu_itr_vld !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_itr: got itr_vld=%b busy=%b exp 0 0", bus.tdt_dm_dtu_itr_vld, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        wr_dly = 0;
        itr_dly = 0;
        rx_val = 32'h0BAD_F00D;
        push(K_WR, 32'hCAFE_F00D);
        push(K_ITR, 32'h7B20_21F3);
        drive_cmd(32'h0023_1003, 32'hCAFE_F00D);
        service(50, -1, 32'd0);
        push(K_ITR, 32'h7B23_9073);
        push(K_RD, 32'd0);
        push(K_UPD, 32'h0BAD_F00D);
        drive_cmd(32'h0022_1007, 32'h0);
        service(50, -1, 32'd0);
        rx_val = 32'h7777_0001;
        push(K_ITR, 32'h7B2F_9073);
        push(K_RD, 32'd0);
        push(K_UPD, 32'h7777_0001);
        drive_cmd(32'h0022_101F, 32'h0);
        service(50, -1, 32'd0);
        checks++;
        if (bus.cmderr !== 3'd0 || bus.data0_upd_data !== 32'h7777_0001) begin
            errors++;
            $display("FAIL b2b: got cmderr=%0d data=%h exp 0 77770001", bus.cmderr, bus.data0_upd_data);
        end
    endtask

`ifdef TDT_DM_ABSCMD_AUTOEXEC_EN
    task automatic test_autoexec();
        wr_dly = 1;
        itr_dly = 1;
        push(K_WR, 32'h0000_0001);
        push(K_ITR, 32'h7B20_22F3);
        drive_cmd(32'h0023_1005, 32'h0000_0001);
        service(50, -1, 32'd0);
        push(K_WR, 32'h55AA_55AA);
        push(K_ITR, 32'h7B20_22F3);
        bus.data0_in = 32'h55AA_55AA;
        bus.autoexec_data0 = 1'b1;
        bus.data0_acc = 1'b1;
        @(negedge clk);
        bus.data0_acc = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL autoexec_busy: got %b exp 1", bus.busy);
        end
        service(50, -1, 32'd0);
        bus.autoexec_data0 = 1'b0;
        checks++;
        if (bus.cmderr !== 3'd0) begin
            errors++;
            $display("FAIL autoexec: got cmderr=%0d exp 0", bus.cmderr);
        end
    endtask
`endif

    initial begin
        bus.cmd_vld = 1'b0;
        bus.cmd_word = '0;
        bus.data0_in = '0;
        bus.cmderr_clr = '0;
        bus.dtu_tdt_dm_halted = 1'b1;
        bus.dtu_tdt_dm_itr_done = 1'b0;
        bus.dtu_tdt_dm_retire_debug_expt_vld = 1'b0;
        bus.dtu_tdt_dm_wr_ready = 1'b0;
        bus.dtu_tdt_dm_rx_data = '0;
`ifdef TDT_DM_ABSCMD_AUTOEXEC_EN
        bus.autoexec_data0 = 1'b0;
        bus.data0_acc = 1'b0;
`endif
        wr_dly = 0;
        itr_dly = 0;
        no_ready = 1'b0;
        expt_en = 1'b0;
        rx_val = '0;
        test_reset();
        test_write();
        test_read();
        test_expt();
        test_errors();
        test_collision();
        test_timeout();
        test_rst_itr();
        test_back_to_back();
`ifdef TDT_DM_ABSCMD_AUTOEXEC_EN
        test_autoexec();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
